// File: rtl/dca_matrix_load_row_issuer_if.sv
// Command, AXI AR, txn-info push and completion signals of the matrix-load row issuer.
// The master modport is the issuer's view; slave is the environment's view.
interface dca_matrix_load_row_issuer_if #(
    parameter int BW_ADDR = 32,
    parameter int BW_ROW  = 8,
    parameter int BW_BEAT = 5
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [BW_ADDR-1:0] cmd_addr;
    logic [BW_ADDR-1:0] cmd_stride;
    logic [BW_ROW-1:0]  cmd_num_row;
    logic [BW_BEAT-1:0] cmd_num_beat;
    logic               arvalid;
    logic               arready;
    logic [BW_ADDR-1:0] araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               txn_valid;
    logic               txn_ready;
    logic [BW_ROW:0]    txn_info;
    logic               rlast_done;
    logic               busy;
    logic               done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_stride, cmd_num_row, cmd_num_beat,
        input  arready, txn_ready, rlast_done,
        output cmd_ready, arvalid, araddr, arlen, arsize, arburst,
        output txn_valid, txn_info, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_stride, cmd_num_row, cmd_num_beat,
        output arready, txn_ready, rlast_done,
        input  cmd_ready, arvalid, araddr, arlen, arsize, arburst,
        input  txn_valid, txn_info, busy, done
    );
endinterface

// File: rtl/dca_matrix_load_row_issuer.sv
// Matrix-load row issuer: one AXI read burst plus one txn-info word per row,
// throttled by the number of bursts whose rlast has not yet been consumed.
module dca_matrix_load_row_issuer #(
    parameter int BW_ADDR         = 32,
    parameter int BW_DATA         = 32,
    parameter int BW_ROW          = 8,
    parameter int BW_BEAT         = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    dca_matrix_load_row_issuer_if.master bus
);
    localparam int                BW_CNT   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [BW_CNT-1:0] CNT_MAX  = BW_CNT'(MAX_OUTSTANDING);
    localparam logic [BW_CNT-1:0] CNT_ZERO = {BW_CNT{1'b0}};
    localparam logic [BW_CNT-1:0] CNT_ONE  = {{(BW_CNT-1){1'b0}}, 1'b1};
    localparam logic [BW_ROW-1:0] ROW_ZERO = {BW_ROW{1'b0}};
    localparam logic [BW_ROW-1:0] ROW_ONE  = {{(BW_ROW-1){1'b0}}, 1'b1};
    localparam logic [2:0]        AR_SIZE  = 3'($clog2(BW_DATA / 8));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [BW_ADDR-1:0] addr_r, addr_nxt_s;
    logic [BW_ADDR-1:0] stride_r, stride_nxt_s;
    logic [BW_ROW-1:0]  num_row_r, num_row_nxt_s;
    logic [BW_ROW-1:0]  row_idx_r, row_idx_nxt_s;
    logic [BW_BEAT-1:0] num_beat_r, num_beat_nxt_s;
    logic               ar_pend_r, ar_pend_nxt_s;
    logic               tx_pend_r, tx_pend_nxt_s;
    logic [BW_CNT-1:0]  cnt_r, cnt_nxt_s;
    logic               done_r, done_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               arvalid_s;
    logic               ar_hs_s;
    logic               tx_hs_s;
    logic               last_s;

    assign arvalid_s  = ar_pend_r & (cnt_r < CNT_MAX);
    assign ar_hs_s    = arvalid_s & bus.arready;
    assign tx_hs_s    = tx_pend_r & bus.txn_ready;
    assign last_s     = (row_idx_r == (num_row_r - ROW_ONE));
    assign busy_nxt_s = (state_nxt_s != ST_IDLE);

    assign bus.cmd_ready = (state_r == ST_IDLE) & ~rst;
    assign bus.arvalid   = arvalid_s;
    assign bus.araddr    = addr_r;
    assign bus.arlen     = 8'(num_beat_r) - 8'd1;
    assign bus.arsize    = AR_SIZE;
    assign bus.arburst   = 2'b01;
    assign bus.txn_valid = tx_pend_r;
    assign bus.txn_info  = {last_s, row_idx_r};
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

    // Outstanding-burst count: AR handshake adds, rlast_done subtracts, saturating at zero.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (ar_hs_s && !bus.rlast_done) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (!ar_hs_s && bus.rlast_done && (cnt_r != CNT_ZERO)) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Next-state and datapath: each pending flag drops on its own handshake.
    always_comb begin
        state_nxt_s    = state_r;
        addr_nxt_s     = addr_r;
        stride_nxt_s   = stride_r;
        num_row_nxt_s  = num_row_r;
        num_beat_nxt_s = num_beat_r;
        row_idx_nxt_s  = row_idx_r;
        ar_pend_nxt_s  = ar_pend_r & ~ar_hs_s;
        tx_pend_nxt_s  = tx_pend_r & ~tx_hs_s;
        done_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_nxt_s     = bus.cmd_addr;
                    stride_nxt_s   = bus.cmd_stride;
                    num_row_nxt_s  = bus.cmd_num_row;
                    num_beat_nxt_s = bus.cmd_num_beat;
                    row_idx_nxt_s  = ROW_ZERO;
                    if (bus.cmd_num_row == ROW_ZERO) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s   = ST_ISSUE;
                        ar_pend_nxt_s = 1'b1;
                        tx_pend_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Next row is armed only once both halves of the current row have handshaken.
                if (!ar_pend_r && !tx_pend_r) begin
                    if (last_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        row_idx_nxt_s = row_idx_r + ROW_ONE;
                        addr_nxt_s    = addr_r + stride_r;
                        ar_pend_nxt_s = 1'b1;
                        tx_pend_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (cnt_nxt_s == CNT_ZERO) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r     <= {BW_ADDR{1'b0}};
            stride_r   <= {BW_ADDR{1'b0}};
            num_row_r  <= ROW_ZERO;
            row_idx_r  <= ROW_ZERO;
            num_beat_r <= {BW_BEAT{1'b0}};
            ar_pend_r  <= 1'b0;
            tx_pend_r  <= 1'b0;
            cnt_r      <= CNT_ZERO;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            addr_r     <= addr_nxt_s;
            stride_r   <= stride_nxt_s;
            num_row_r  <= num_row_nxt_s;
            row_idx_r  <= row_idx_nxt_s;
            num_beat_r <= num_beat_nxt_s;
            ar_pend_r  <= ar_pend_nxt_s;
            tx_pend_r  <= tx_pend_nxt_s;
            cnt_r      <= cnt_nxt_s;
            done_r     <= done_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end
endmodule
